median3_stream_ctrl: RTL and testbench

Streaming scheduler that shares a single 3-input median comparator, the same combinational min/max/median network as the existing `sorting` block, between two sample channels. Each channel keeps its own 3-sample sliding window. A round-robin arbiter accepts at most one sample per cycle. Results leave through one registered valid/ready port tagged with the channel id. It sits between per-channel sample sources and the downstream filter consumer.

---
 rtl/median3_stream_ctrl.sv | 151 +++++++++++++++
 tb/tb_median3_stream_ctrl.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/median3_stream_ctrl.sv
// Two-channel streaming 3-tap median filter sharing one median network.
// Round-robin admission, one accept per cycle, single registered valid/ready result port.
module median3_stream_ctrl #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         s0_valid,
    output logic         s0_ready,
    input  logic [W-1:0] s0_data,
    input  logic         s0_last,
    input  logic         s1_valid,
    output logic         s1_ready,
    input  logic [W-1:0] s1_data,
    input  logic         s1_last,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [W-1:0] m_data,
    output logic         m_ch
);

    logic [W-1:0] w_old_q [2];
    logic [W-1:0] w_old_d [2];
    logic [W-1:0] w_mid_q [2];
    logic [W-1:0] w_mid_d [2];
    logic [1:0]   cnt_q   [2];
    logic [1:0]   cnt_d   [2];
    logic         rr_q, rr_d;
    logic         m_valid_q, m_valid_d;
    logic         m_ch_q, m_ch_d;
    logic [W-1:0] m_data_q, m_data_d;

    logic [1:0]   in_valid;
    logic [1:0]   in_last;
    logic [W-1:0] in_data [2];
    logic [1:0]   elig;
    logic [1:0]   grant;
    logic         slot_free;
    logic         accept;
    logic         sel;
    logic         sel_last;
    logic         sel_full;
    logic [W-1:0] sel_x, sel_old, sel_mid;
    logic [W-1:0] lo_ab, hi_ab, hi_c, med;

    assign in_valid   = {s1_valid, s0_valid};
    assign in_last    = {s1_last, s0_last};
    assign in_data[0] = s0_data;
    assign in_data[1] = s1_data;

    assign slot_free = !m_valid_q || m_ready;

    // Warm-up samples never touch the output slot, so they ignore backpressure.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_elig
            assign elig[gi] = in_valid[gi] && ((cnt_q[gi] != 2'd2) || slot_free);
        end
    endgenerate

    always_comb begin
        grant = 2'b00;
        if (!rst) begin
            if (elig == 2'b11) begin
                grant = rr_q ? 2'b10 : 2'b01;
            end else begin
                grant = elig;
            end
        end
    end

    assign s0_ready = grant[0];
    assign s1_ready = grant[1];
    assign accept   = |grant;
    assign sel      = grant[1];
    assign sel_x    = in_data[sel];
    assign sel_last = in_last[sel];
    assign sel_old  = w_old_q[sel];
    assign sel_mid  = w_mid_q[sel];
    assign sel_full = (cnt_q[sel] == 2'd2);

    // median(a,b,c) = max(min(a,b), min(max(a,b), c))
    assign lo_ab = (sel_old < sel_mid) ? sel_old : sel_mid;
    assign hi_ab = (sel_old < sel_mid) ? sel_mid : sel_old;
    assign hi_c  = (hi_ab < sel_x) ? hi_ab : sel_x;
    assign med   = (lo_ab > hi_c) ? lo_ab : hi_c;

    always_comb begin
        rr_d      = rr_q;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_ch_d    = m_ch_q;
        for (int i = 0; i < 2; i++) begin
            w_old_d[i] = w_old_q[i];
            w_mid_d[i] = w_mid_q[i];
            cnt_d[i]   = cnt_q[i];
        end

        if (m_valid_q && m_ready) begin
            m_valid_d = 1'b0;
        end

        if (accept) begin
            rr_d = ~sel;
            if (sel_full) begin
                m_valid_d = 1'b1;
                m_data_d  = med;
                m_ch_d    = sel;
            end
            if (sel_last) begin
                w_old_d[sel] = '0;
                w_mid_d[sel] = '0;
                cnt_d[sel]   = 2'd0;
            end else begin
                w_old_d[sel] = sel_mid;
                w_mid_d[sel] = sel_x;
                if (!sel_full) begin
                    cnt_d[sel] = cnt_q[sel] + 2'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q      <= 1'b0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_ch_q    <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                w_old_q[i] <= '0;
                w_mid_q[i] <= '0;
                cnt_q[i]   <= 2'd0;
            end
        end else begin
            rr_q      <= rr_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_ch_q    <= m_ch_d;
            for (int i = 0; i < 2; i++) begin
                w_old_q[i] <= w_old_d[i];
                w_mid_q[i] <= w_mid_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign m_ch    = m_ch_q;

endmodule

// File: tb/tb_median3_stream_ctrl.sv
// Self-checking bench for median3_stream_ctrl: scenario tasks drive samples,
// expected results queue up at accept time and are matched against each output handshake.
module tb_median3_stream_ctrl;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         s0_valid, s0_ready, s0_last;
    logic [W-1:0] s0_data;
    logic         s1_valid, s1_ready, s1_last;
    logic [W-1:0] s1_data;
    logic         m_valid, m_ready, m_ch;
    logic [W-1:0] m_data;

    typedef struct packed {
        logic [W-1:0] data;
        logic         ch;
    } res_t;

    res_t sb[$];
    res_t mon_exp;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    median3_stream_ctrl #(.W(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .s0_valid (s0_valid),
        .s0_ready (s0_ready),
        .s0_data  (s0_data),
        .s0_last  (s0_last),
        .s1_valid (s1_valid),
        .s1_ready (s1_ready),
        .s1_data  (s1_data),
        .s1_last  (s1_last),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .m_ch     (m_ch)
    );

    // Output handshake monitor: one line per delivered result.
    always @(negedge clk) begin
        if (!rst && m_valid === 1'b1 && m_ready === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL out_unexpected: got data=%0d ch=%0d, required no output", m_data, m_ch);
            end else begin
                mon_exp = sb.pop_front();
                if (m_data !== mon_exp.data || m_ch !== mon_exp.ch) begin
                    errors++;
                    $display("FAIL out_result: got data=%0d ch=%0d, required data=%0d ch=%0d",
                             m_data, m_ch, mon_exp.data, mon_exp.ch);
                end else begin
                    $display("out data=%0d ch=%0d ok", m_data, m_ch);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Tasks are entered and left at a falling edge so inputs never change near a rising edge.
    task automatic send(input bit ch, input logic [W-1:0] d, input bit last,
                        input bit has_res, input logic [W-1:0] exp_d, input bit chk_lat);
        int   n;
        res_t r;
        if (ch) begin
            s1_valid = 1'b1; s1_data = d; s1_last = last;
        end else begin
            s0_valid = 1'b1; s0_data = d; s0_last = last;
        end
        for (n = 0; n < 50; n++) begin
            #1;
            if ((ch ? s1_ready : s0_ready) === 1'b1) break;
            @(negedge clk);
        end
        if (n == 50) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout ch%0d data=%0d: ready stayed 0, required 1", ch, d);
            s0_valid = 1'b0; s1_valid = 1'b0;
            return;
        end
        if (has_res) begin
            r.data = exp_d;
            r.ch   = ch;
            sb.push_back(r);
        end
        @(posedge clk);
        #1;
        if (ch) begin
            s1_valid = 1'b0; s1_last = 1'b0;
        end else begin
            s0_valid = 1'b0; s0_last = 1'b0;
        end
        @(negedge clk);
        $display("send ch%0d data=%0d last=%0d", ch, d, last);
        if (chk_lat) begin
            checks++;
            if (m_valid !== has_res) begin
                errors++;
                $display("FAIL latency ch%0d data=%0d: m_valid=%0b one cycle after accept, required %0b",
                         ch, d, m_valid, has_res);
            end
        end
    endtask

    task automatic do_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d results never delivered, required 0", sb.size());
            sb.delete();
        end
        rst = 1'b1;
        s0_valid = 1'b0; s0_last = 1'b0;
        s1_valid = 1'b0; s1_last = 1'b0;
        m_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; m_ready = 1'b1;
        s0_valid = 1'b1; s0_data = 8'd7; s0_last = 1'b0;
        s1_valid = 1'b1; s1_data = 8'd9; s1_last = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (m_valid !== 1'b0 || m_data !== '0 || m_ch !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: m_valid=%0b m_data=%0d m_ch=%0b, required 0 0 0", m_valid, m_data, m_ch);
        end
        checks++;
        if (s0_ready !== 1'b0 || s1_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: s0_ready=%0b s1_ready=%0b, required 0 0", s0_ready, s1_ready);
        end
        s0_valid = 1'b0; s1_valid = 1'b0;
        rst = 1'b0;
        $display("reset checked");
    endtask

    task automatic test_single_channel();
        do_reset();
        send(0, 8'd5, 0, 0, 0, 1);
        send(0, 8'd1, 0, 0, 0, 1);
        send(0, 8'd3, 0, 1, 8'd3, 1);
        send(0, 8'd7, 0, 1, 8'd3, 1);
    endtask

    task automatic test_value_corners();
        do_reset();
        send(0, 8'd7,   0, 0, 0, 1);
        send(0, 8'd7,   0, 0, 0, 1);
        send(0, 8'd7,   1, 1, 8'd7, 1);
        send(0, 8'd255, 0, 0, 0, 1);
        send(0, 8'd128, 0, 0, 0, 1);
        send(0, 8'd0,   1, 1, 8'd128, 1);
        send(0, 8'd4,   0, 0, 0, 1);
        send(0, 8'd4,   0, 0, 0, 1);
        send(0, 8'd2,   1, 1, 8'd4, 1);
        send(0, 8'd2,   0, 0, 0, 1);
        send(0, 8'd4,   0, 0, 0, 1);
        send(0, 8'd4,   1, 1, 8'd4, 1);
        send(0, 8'd0,   0, 0, 0, 1);
        send(0, 8'd0,   0, 0, 0, 1);
        send(0, 8'd0,   1, 1, 8'd0, 1);
    endtask

    task automatic test_round_robin();
        logic [W-1:0] d0 [4];
        logic [W-1:0] d1 [4];
        logic [W-1:0] r0 [4];
        logic [W-1:0] r1 [4];
        int   i0, i1;
        bit   rr_m, exp_ch;
        res_t r;
        d0 = '{8'd1, 8'd2, 8'd3, 8'd4};
        d1 = '{8'd200, 8'd50, 8'd150, 8'd10};
        r0 = '{8'd0, 8'd0, 8'd2, 8'd3};
        r1 = '{8'd0, 8'd0, 8'd150, 8'd50};
        do_reset();
        i0 = 0; i1 = 0; rr_m = 1'b0;
        for (int cyc = 0; cyc < 20 && (i0 < 4 || i1 < 4); cyc++) begin
            s0_valid = (i0 < 4); s0_data = (i0 < 4) ? d0[i0] : '0; s0_last = 1'b0;
            s1_valid = (i1 < 4); s1_data = (i1 < 4) ? d1[i1] : '0; s1_last = 1'b0;
            #1;
            exp_ch = (i0 < 4 && i1 < 4) ? rr_m : ((i0 < 4) ? 1'b0 : 1'b1);
            checks++;
            if (s0_ready !== (exp_ch == 1'b0) || s1_ready !== (exp_ch == 1'b1)) begin
                errors++;
                $display("FAIL rr_grant cycle %0d: s0_ready=%0b s1_ready=%0b, required grant to ch%0d",
                         cyc, s0_ready, s1_ready, exp_ch);
            end
            if (s0_ready === 1'b1) begin
                if (i0 >= 2) begin r.data = r0[i0]; r.ch = 1'b0; sb.push_back(r); end
                $display("rr accept ch0 data=%0d", d0[i0]);
                i0++; rr_m = 1'b1;
            end else if (s1_ready === 1'b1) begin
                if (i1 >= 2) begin r.data = r1[i1]; r.ch = 1'b1; sb.push_back(r); end
                $display("rr accept ch1 data=%0d", d1[i1]);
                i1++; rr_m = 1'b0;
            end
            @(negedge clk);
        end
        s0_valid = 1'b0; s1_valid = 1'b0;
        checks++;
        if (i0 != 4 || i1 != 4) begin
            errors++;
            $display("FAIL rr_progress: accepted ch0=%0d ch1=%0d, required 4 4", i0, i1);
        end
    endtask

    task automatic test_reset_mid_frame();
        do_reset();
        send(1, 8'd1, 0, 0, 0, 1);
        send(1, 8'd2, 0, 0, 0, 1);
        send(1, 8'd3, 1, 1, 8'd2, 1);
        send(0, 8'd10, 0, 0, 0, 1);
        send(0, 8'd20, 0, 0, 0, 1);
        rst = 1'b1;
        s0_valid = 1'b1; s0_data = 8'd99;
        s1_valid = 1'b1; s1_data = 8'd98;
        #1;
        checks++;
        if (s0_ready !== 1'b0 || s1_ready !== 1'b0) begin
            errors++;
            $display("FAIL midreset_ready: s0_ready=%0b s1_ready=%0b, required 0 0", s0_ready, s1_ready);
        end
        @(negedge clk);
        checks++;
        if (m_valid !== 1'b0 || m_data !== '0 || m_ch !== 1'b0 || s0_ready !== 1'b0 || s1_ready !== 1'b0) begin
            errors++;
            $display("FAIL midreset_outputs: m_valid=%0b m_data=%0d m_ch=%0b ready=%0b%0b, required all 0",
                     m_valid, m_data, m_ch, s1_ready, s0_ready);
        end
        rst = 1'b0;
        s0_valid = 1'b0; s1_valid = 1'b0;
        $display("mid-frame reset applied");
        send(0, 8'd30, 0, 0, 0, 1);
        send(0, 8'd40, 0, 0, 0, 1);
        send(0, 8'd50, 0, 1, 8'd40, 1);
    endtask

    task automatic test_backpressure();
        res_t r;
        do_reset();
        @(posedge clk);
        #1;
        m_ready = 1'b0;
        @(negedge clk);
        send(0, 8'd5, 0, 0, 0, 1);
        send(0, 8'd1, 0, 0, 0, 1);
        send(0, 8'd3, 0, 1, 8'd3, 1);
        s0_valid = 1'b1; s0_data = 8'd2; s0_last = 1'b0;
        s1_valid = 1'b1; s1_data = 8'd9; s1_last = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (s0_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_stall cycle %0d: s0_ready=%0b, required 0", i, s0_ready);
            end
            checks++;
            if (s1_ready !== (i == 0)) begin
                errors++;
                $display("FAIL bp_warmup cycle %0d: s1_ready=%0b, required %0b", i, s1_ready, (i == 0));
            end
            checks++;
            if (m_valid !== 1'b1 || m_data !== 8'd3 || m_ch !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold cycle %0d: m_valid=%0b m_data=%0d m_ch=%0b, required 1 3 0",
                         i, m_valid, m_data, m_ch);
            end
            @(posedge clk);
            #1;
            s1_valid = 1'b0;
            @(negedge clk);
        end
        $display("backpressure held 3 cycles");
        @(posedge clk);
        #1;
        m_ready = 1'b1;
        #1;
        checks++;
        if (s0_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: s0_ready=%0b after m_ready rose, required 1", s0_ready);
        end else begin
            r.data = 8'd2; r.ch = 1'b0;
            sb.push_back(r);
        end
        @(posedge clk);
        #1;
        s0_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (m_valid !== 1'b1 || m_data !== 8'd2) begin
            errors++;
            $display("FAIL bp_resume: m_valid=%0b m_data=%0d, required 1 2", m_valid, m_data);
        end
    endtask

    task automatic test_frame_boundary();
        do_reset();
        send(0, 8'd42,  0, 0, 0, 1);
        send(0, 8'd100, 0, 0, 0, 1);
        send(0, 8'd17,  1, 1, 8'd42, 1);
        send(0, 8'd9,   0, 0, 0, 1);
        send(0, 8'd9,   1, 0, 0, 1);
        send(0, 8'd9,   0, 0, 0, 1);
        send(0, 8'd9,   0, 0, 0, 1);
        send(0, 8'd1,   0, 1, 8'd9, 1);
    endtask

    initial begin
        rst = 1'b1; m_ready = 1'b1;
        s0_valid = 1'b0; s0_data = '0; s0_last = 1'b0;
        s1_valid = 1'b0; s1_data = '0; s1_last = 1'b0;
        @(negedge clk);
        test_reset();
        test_single_channel();
        test_value_corners();
        test_round_robin();
        test_reset_mid_frame();
        test_backpressure();
        test_frame_boundary();
        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL final_drain: %0d results never delivered, required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
